// File: rtl/regfile_hs_reader.sv
// regfile_hs_reader
//   Register file with one direct write port and a dual read port served over
//   a 4-phase RD_REQ/RD_ACK handshake. Read addresses are captured in IDLE,
//   data is loaded on the following edge, and RD_DATA1/2 stay frozen while
//   RD_ACK is high and afterwards until the next fetch.
// Ports
//   CLK       system clock, rising edge
//   RESET     asynchronous active-low reset
//   WR_EN     write strobe
//   WR_ADDR   write address
//   WR_DATA   write data
//   RD_REQ    read request
//   RD_ADDR1  read address, port 1 (captured in IDLE only)
//   RD_ADDR2  read address, port 2 (captured in IDLE only)
//   RD_ACK    read acknowledge; RD_DATA1/2 valid while high
//   RD_DATA1  data of captured address 1
//   RD_DATA2  data of captured address 2
module regfile_hs_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_REQ,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR1,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR2,
    output logic                  RD_ACK,
    output logic [DATA_WIDTH-1:0] RD_DATA1,
    output logic [DATA_WIDTH-1:0] RD_DATA2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;

    // State register and all storage.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            addr1_q <= '0;
            addr2_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Write port, independent of the read handshake.
    always_comb begin
        regs_d = regs_q;
        if (WR_EN && !(ZERO_REG != 0 && WR_ADDR == '0)) begin
            regs_d[WR_ADDR] = WR_DATA;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (RD_REQ) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_ACK;
            ST_ACK:   if (!RD_REQ) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Address capture and data load. Fetching from regs_d (the post-write
    // view) forwards a same-edge write to a captured address.
    always_comb begin
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        if (state_q == ST_IDLE && RD_REQ) begin
            addr1_d = RD_ADDR1;
            addr2_d = RD_ADDR2;
        end
        if (state_q == ST_FETCH) begin
            data1_d = (ZERO_REG != 0 && addr1_q == '0) ? '0 : regs_d[addr1_q];
            data2_d = (ZERO_REG != 0 && addr2_q == '0) ? '0 : regs_d[addr2_q];
        end
    end

    // Outputs.
    always_comb begin
        RD_ACK   = (state_q == ST_ACK);
        RD_DATA1 = data1_q;
        RD_DATA2 = data2_q;
    end

endmodule

// File: tb/tb_regfile_hs_reader.sv
module tb_regfile_hs_reader;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          RD_REQ;
    logic [AW-1:0] RD_ADDR1;
    logic [AW-1:0] RD_ADDR2;

    logic          ack_z, ack_n;
    logic [DW-1:0] d1_z, d2_z, d1_n, d2_n;

    int checks   = 0;
    int failures = 0;

    // Reference contents: m_z for the ZERO_REG=1 instance, m_n for ZERO_REG=0.
    logic [DW-1:0] m_z [32];
    logic [DW-1:0] m_n [32];

    always #5 CLK = ~CLK;

    regfile_hs_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RD_REQ(RD_REQ), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
        .RD_ACK(ack_z), .RD_DATA1(d1_z), .RD_DATA2(d2_z)
    );

    regfile_hs_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_n (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .RD_REQ(RD_REQ), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
        .RD_ACK(ack_n), .RD_DATA1(d1_n), .RD_DATA2(d2_n)
    );

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            m_z[i] = '0;
            m_n[i] = '0;
        end
    endtask

    // One clock edge; the model absorbs whatever write is presented at it.
    task automatic step();
        @(posedge CLK);
        if (RESET && WR_EN) begin
            if (WR_ADDR != 0) m_z[WR_ADDR] = WR_DATA;
            m_n[WR_ADDR] = WR_DATA;
        end
        #1;
    endtask

    function automatic logic [DW-1:0] ez(input logic [AW-1:0] a);
        return (a == 0) ? '0 : m_z[a];
    endfunction

    function automatic logic [DW-1:0] en(input logic [AW-1:0] a);
        return m_n[a];
    endfunction

    task automatic rand_write();
        WR_EN   = 1'($urandom_range(0, 1));
        WR_ADDR = AW'($urandom);
        WR_DATA = $urandom;
    endtask

    task automatic test_reset();
        logic [2*DW:0] got, exp;
        RESET = 1'b0; WR_EN = 1'b0; RD_REQ = 1'b0;
        WR_ADDR = '0; WR_DATA = '0; RD_ADDR1 = '0; RD_ADDR2 = '0;
        clear_model();
        #3;
        got = {ack_z, d1_z, d2_z}; exp = '0; checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_init_z: got=%h exp=%h", got, exp); end
        got = {ack_n, d1_n, d2_n}; checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_init_n: got=%h exp=%h", got, exp); end
        step(); step();
        RESET = 1'b1;
        WR_EN = 1'b1; WR_ADDR = 5; WR_DATA = 32'hCAFE0005;
        step();
        WR_EN = 1'b0;
        RD_REQ = 1'b1; RD_ADDR1 = 5; RD_ADDR2 = 5;
        step(); step();
        got = {ack_z, d1_z, d2_z}; exp = {1'b1, 32'hCAFE0005, 32'hCAFE0005}; checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_pre_ack: got=%h exp=%h", got, exp); end
        // Asynchronous reset in the middle of ACK, checked before the next edge.
        #2 RESET = 1'b0;
        #1;
        clear_model();
        got = {ack_z, d1_z, d2_z}; exp = '0; checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_mid_ack_z: got=%h exp=%h", got, exp); end
        got = {ack_n, d1_n, d2_n}; checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_mid_ack_n: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
        RESET = 1'b1;
        RD_REQ = 1'b1; RD_ADDR1 = 5; RD_ADDR2 = 5;
        step(); step();
        got = {ack_n, d1_n, d2_n}; exp = {1'b1, 64'h0}; checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_r5_cleared: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [2*DW:0] got, exp;
        WR_EN = 1'b1; WR_ADDR = 3; WR_DATA = 32'h12345678;
        step();
        WR_ADDR = 7; WR_DATA = 32'hFFFFFFFF;
        step();
        WR_EN = 1'b0;
        RD_REQ = 1'b1; RD_ADDR1 = 3; RD_ADDR2 = 7;
        step();
        got = {ack_z, ack_n}; exp = '0; checks++;
        if (got !== exp) begin failures++; $display("FAIL basic_fetch_ack_low: got=%h exp=%h", got, exp); end
        step();
        got = {ack_z, d1_z, d2_z}; exp = {1'b1, 32'h12345678, 32'hFFFFFFFF}; checks++;
        if (got !== exp) begin failures++; $display("FAIL basic_z: got=%h exp=%h", got, exp); end
        got = {ack_n, d1_n, d2_n}; checks++;
        if (got !== exp) begin failures++; $display("FAIL basic_n: got=%h exp=%h", got, exp); end
    endtask

    // Entered in ACK of the (3,7) transaction with RD_REQ still high.
    task automatic test_hold();
        logic [2*DW:0] got, exp;
        exp = {1'b1, 32'h12345678, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            WR_EN = 1'b1; WR_ADDR = 3; WR_DATA = 32'h00001000;
            RD_ADDR1 = AW'($urandom); RD_ADDR2 = AW'($urandom);
            step();
            got = {ack_z, d1_z, d2_z}; checks++;
            if (got !== exp) begin failures++; $display("FAIL hold_cycle%0d: got=%h exp=%h", i, got, exp); end
        end
        WR_EN = 1'b0; RD_REQ = 1'b0;
        step();
        got = {ack_z, d1_z, d2_z}; exp = {1'b0, 32'h12345678, 32'hFFFFFFFF}; checks++;
        if (got !== exp) begin failures++; $display("FAIL hold_release: got=%h exp=%h", got, exp); end
        step();
        got = {ack_n, d1_n, d2_n}; checks++;
        if (got !== exp) begin failures++; $display("FAIL hold_idle_keep: got=%h exp=%h", got, exp); end
    endtask

    task automatic test_forward();
        logic [2*DW:0] got, exp;
        RD_REQ = 1'b1; RD_ADDR1 = 9; RD_ADDR2 = 9;
        step();
        WR_EN = 1'b1; WR_ADDR = 9; WR_DATA = 32'hDEADBEEF;
        step();
        WR_EN = 1'b0;
        got = {ack_z, d1_z, d2_z}; exp = {1'b1, 32'hDEADBEEF, 32'hDEADBEEF}; checks++;
        if (got !== exp) begin failures++; $display("FAIL forward_z: got=%h exp=%h", got, exp); end
        got = {ack_n, d1_n, d2_n}; checks++;
        if (got !== exp) begin failures++; $display("FAIL forward_n: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
    endtask

    task automatic test_zero();
        logic [2*DW:0] got, exp;
        WR_EN = 1'b1; WR_ADDR = 0; WR_DATA = 32'hAAAAAAAA;
        step();
        WR_EN = 1'b0;
        RD_REQ = 1'b1; RD_ADDR1 = 0; RD_ADDR2 = 3;
        step(); step();
        got = {ack_z, d1_z, d2_z}; exp = {1'b1, 32'h0, 32'h00001000}; checks++;
        if (got !== exp) begin failures++; $display("FAIL zero_read_z: got=%h exp=%h", got, exp); end
        got = {ack_n, d1_n, d2_n}; exp = {1'b1, 32'hAAAAAAAA, 32'h00001000}; checks++;
        if (got !== exp) begin failures++; $display("FAIL zero_read_n: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
        // A forwarded write to r0 must still read as zero when ZERO_REG=1.
        RD_REQ = 1'b1; RD_ADDR1 = 0; RD_ADDR2 = 0;
        step();
        WR_EN = 1'b1; WR_ADDR = 0; WR_DATA = 32'h55555555;
        step();
        WR_EN = 1'b0;
        got = {ack_z, d1_z, d2_z}; exp = {1'b1, 64'h0}; checks++;
        if (got !== exp) begin failures++; $display("FAIL zero_forward_z: got=%h exp=%h", got, exp); end
        got = {ack_n, d1_n, d2_n}; exp = {1'b1, 32'h55555555, 32'h55555555}; checks++;
        if (got !== exp) begin failures++; $display("FAIL zero_forward_n: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [2*DW:0] got, exp;
        RD_REQ = 1'b1; RD_ADDR1 = 3; RD_ADDR2 = 9;
        step();
        RD_ADDR1 = 7; RD_ADDR2 = 0;
        step();
        got = {ack_z, d1_z, d2_z}; exp = {1'b1, ez(3), ez(9)}; checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_first: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
        RD_REQ = 1'b1; RD_ADDR1 = 5; RD_ADDR2 = 7;
        step();
        RD_ADDR1 = 3; RD_ADDR2 = 3;
        step();
        got = {ack_n, d1_n, d2_n}; exp = {1'b1, en(5), en(7)}; checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_second: got=%h exp=%h", got, exp); end
        RD_REQ = 1'b0;
        step();
        got = {ack_z, ack_n}; exp = '0; checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_release: got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        logic [2*DW:0] got, exp_z, exp_n;
        logic [AW-1:0] a1, a2;
        int hold;
        for (int t = 0; t < 40; t++) begin
            a1 = AW'($urandom); a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom);
            RD_REQ = 1'b1; RD_ADDR1 = a1; RD_ADDR2 = a2;
            rand_write();
            step();
            got = {ack_z, ack_n}; checks++;
            if (got !== 2'b00) begin failures++; $display("FAIL rnd%0d_fetch: got=%h exp=0", t, got); end
            RD_ADDR1 = AW'($urandom); RD_ADDR2 = AW'($urandom);
            rand_write();
            step();
            exp_z = {1'b1, ez(a1), ez(a2)};
            exp_n = {1'b1, en(a1), en(a2)};
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                got = {ack_z, d1_z, d2_z}; checks++;
                if (got !== exp_z) begin failures++; $display("FAIL rnd%0d_z: got=%h exp=%h", t, got, exp_z); end
                got = {ack_n, d1_n, d2_n}; checks++;
                if (got !== exp_n) begin failures++; $display("FAIL rnd%0d_n: got=%h exp=%h", t, got, exp_n); end
                if (h == hold) RD_REQ = 1'b0;
                RD_ADDR1 = AW'($urandom); RD_ADDR2 = AW'($urandom);
                rand_write();
                step();
            end
            exp_z[2*DW] = 1'b0;
            exp_n[2*DW] = 1'b0;
            got = {ack_z, d1_z, d2_z}; checks++;
            if (got !== exp_z) begin failures++; $display("FAIL rnd%0d_rel_z: got=%h exp=%h", t, got, exp_z); end
            got = {ack_n, d1_n, d2_n}; checks++;
            if (got !== exp_n) begin failures++; $display("FAIL rnd%0d_rel_n: got=%h exp=%h", t, got, exp_n); end
            WR_EN = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_forward();
        test_zero();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
